// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   rx_state_t    : receiver FSM states
//   parity_mode_t : encoding of the parity_mode configuration input
//   parity_enabled: true when a parity bit is present in the frame
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP1      = 3'd4,
        ST_STOP2      = 3'd5,
        ST_BREAK_WAIT = 3'd6
    } rx_state_t;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'b00,
        PARITY_EVEN = 2'b01,
        PARITY_ODD  = 2'b10,
        PARITY_RSVD = 2'b11   // behaves as no parity
    } parity_mode_t;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : forces the count back to 0 on the next edge
//   bit_length     : clock periods per bit minus 1
//   mid_bit        : count is at the bit centre (bit_length >> 1)
//   end_bit        : count is at the last cycle of the bit period
module uart_bit_timer #(
    parameter int BIT_LENGTH_WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic [BIT_LENGTH_WIDTH-1:0] bit_length,
    output logic                        mid_bit,
    output logic                        end_bit
);

    logic [BIT_LENGTH_WIDTH-1:0] count_reg;

    assign end_bit = (count_reg == bit_length);
    assign mid_bit = (count_reg == (bit_length >> 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear || end_bit) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + BIT_LENGTH_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with ready/valid result handshake.
//   clock, reset_n  : clock and asynchronous active-low reset
//   rxd             : asynchronous serial line, idle high
//   bit_length      : clock periods per bit minus 1 (sampled in IDLE)
//   parity_mode     : 00 none, 01 even, 10 odd, 11 none (sampled in IDLE)
//   two_stop        : check a second stop bit (sampled in IDLE)
//   data/valid/ready: received word, LSB first on the line, and handshake
//   frame_error, parity_error, break_detect : per-frame flags, qualified by valid
//   overrun         : one-cycle pulse when a completed frame is dropped
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int BIT_LENGTH_WIDTH = 16,
    parameter int DATA_WIDTH       = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        rxd,
    input  logic [BIT_LENGTH_WIDTH-1:0] bit_length,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    output logic [DATA_WIDTH-1:0]       data,
    output logic                        valid,
    input  logic                        ready,
    output logic                        frame_error,
    output logic                        parity_error,
    output logic                        break_detect,
    output logic                        overrun
);

    localparam int BIT_CNT_WIDTH = 4;
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    logic [1:0]                  sync_reg;
    logic                        rx_line;
    rx_state_t                   state_reg;
    logic [BIT_LENGTH_WIDTH-1:0] cfg_bit_length_reg;
    logic [1:0]                  cfg_parity_reg;
    logic                        cfg_two_stop_reg;
    logic [DATA_WIDTH-1:0]       shift_reg;
    logic [BIT_CNT_WIDTH-1:0]    bit_cnt_reg;
    logic                        parity_bit_reg;
    logic                        parity_err_acc_reg;
    logic                        frame_err_acc_reg;
    logic [DATA_WIDTH-1:0]       data_reg;
    logic                        valid_reg;
    logic                        frame_error_reg;
    logic                        parity_error_reg;
    logic                        break_detect_reg;
    logic                        overrun_reg;

    logic timer_clear;
    logic mid_bit;
    logic end_bit_unused;   // bit period wrap is handled inside the timer
    logic is_break;
    logic done;
    logic done_fe;
    logic done_pe;

    // Two-flop synchronizer; the line idles high so it resets to 11.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
        end
    end
    assign rx_line = sync_reg[1];

    // Holding the timer clear in IDLE makes the count start at 0 in START.
    assign timer_clear = (state_reg == ST_IDLE) || (state_reg == ST_BREAK_WAIT);

    uart_bit_timer #(
        .BIT_LENGTH_WIDTH(BIT_LENGTH_WIDTH)
    ) u_bit_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (timer_clear),
        .bit_length(cfg_bit_length_reg),
        .mid_bit   (mid_bit),
        .end_bit   (end_bit_unused)
    );

    // Frame completion is decided at the centre of the last stop bit. A break
    // finishes at the first stop bit even when two stop bits are configured.
    always_comb begin
        is_break = 1'b0;
        done     = 1'b0;
        done_fe  = 1'b0;
        done_pe  = parity_err_acc_reg;
        if (mid_bit) begin
            if (state_reg == ST_STOP1) begin
                is_break = !rx_line && (shift_reg == '0) &&
                           !(parity_enabled(cfg_parity_reg) && parity_bit_reg);
                if (is_break || !cfg_two_stop_reg) begin
                    done    = 1'b1;
                    done_fe = !rx_line;
                end
            end else if (state_reg == ST_STOP2) begin
                done    = 1'b1;
                done_fe = frame_err_acc_reg | !rx_line;
            end
        end
        if (is_break) begin
            done_pe = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_IDLE;
            cfg_bit_length_reg <= '0;
            cfg_parity_reg     <= PARITY_NONE;
            cfg_two_stop_reg   <= 1'b0;
            shift_reg          <= '0;
            bit_cnt_reg        <= '0;
            parity_bit_reg     <= 1'b0;
            parity_err_acc_reg <= 1'b0;
            frame_err_acc_reg  <= 1'b0;
            data_reg           <= '0;
            valid_reg          <= 1'b0;
            frame_error_reg    <= 1'b0;
            parity_error_reg   <= 1'b0;
            break_detect_reg   <= 1'b0;
            overrun_reg        <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
            // A held, unaccepted result wins over the new frame.
            if (done) begin
                if (valid_reg && !ready) begin
                    overrun_reg <= 1'b1;
                end else begin
                    data_reg         <= shift_reg;
                    valid_reg        <= 1'b1;
                    frame_error_reg  <= done_fe;
                    parity_error_reg <= done_pe;
                    break_detect_reg <= is_break;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    cfg_bit_length_reg <= bit_length;
                    cfg_parity_reg     <= parity_mode;
                    cfg_two_stop_reg   <= two_stop;
                    bit_cnt_reg        <= '0;
                    parity_bit_reg     <= 1'b0;
                    parity_err_acc_reg <= 1'b0;
                    frame_err_acc_reg  <= 1'b0;
                    if (!rx_line) begin
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (mid_bit) begin
                        state_reg <= rx_line ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid_bit) begin
                        shift_reg   <= {rx_line, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + BIT_CNT_WIDTH'(1);
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg <= parity_enabled(cfg_parity_reg) ? ST_PARITY : ST_STOP1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (mid_bit) begin
                        parity_bit_reg     <= rx_line;
                        // Even: XOR of word and parity must be 0; odd: must be 1.
                        parity_err_acc_reg <= (^shift_reg ^ rx_line) ^ (cfg_parity_reg == PARITY_ODD);
                        state_reg          <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (mid_bit) begin
                        if (is_break) begin
                            state_reg <= ST_BREAK_WAIT;
                        end else if (done) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            frame_err_acc_reg <= !rx_line;
                            state_reg         <= ST_STOP2;
                        end
                    end
                end
                ST_STOP2: begin
                    if (mid_bit) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_BREAK_WAIT: begin
                    if (rx_line) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign data         = data_reg;
    assign valid        = valid_reg;
    assign frame_error  = frame_error_reg;
    assign parity_error = parity_error_reg;
    assign break_detect = break_detect_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

    localparam int BLW = 16;
    localparam int DW  = 8;
    localparam int BL  = 15;
    localparam int BT  = BL + 1;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           rxd = 1'b1;
    logic [BLW-1:0] bit_length = BLW'(BL);
    logic [1:0]     parity_mode = 2'b00;
    logic           two_stop = 1'b0;
    logic           ready = 1'b0;
    logic [DW-1:0]  data;
    logic           valid;
    logic           frame_error;
    logic           parity_error;
    logic           break_detect;
    logic           overrun;

    int   checks = 0;
    int   failures = 0;
    int   ovr_cnt = 0;
    int   rise_cnt = 0;
    logic valid_q = 1'b0;
    int   r0;
    int   o0;

    always #5 clock = ~clock;

    uart_rx_cfg #(
        .BIT_LENGTH_WIDTH(BLW),
        .DATA_WIDTH      (DW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rxd         (rxd),
        .bit_length  (bit_length),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_error (frame_error),
        .parity_error(parity_error),
        .break_detect(break_detect),
        .overrun     (overrun)
    );

    // Count overrun pulses and valid rising edges, sampled mid-cycle.
    always @(negedge clock) begin
        if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
        if (valid === 1'b1 && valid_q !== 1'b1) rise_cnt <= rise_cnt + 1;
        valid_q <= valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BT) @(posedge clock);
        #1;
    endtask

    task automatic drive_start_data(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic s1, input logic has_s2, input logic s2);
        drive_start_data(d);
        if (has_par) drive_bit(pbit);
        drive_bit(s1);
        if (has_s2) drive_bit(s2);
        rxd = 1'b1;
        repeat (BT) @(posedge clock);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic fe,
                               input logic pe, input logic brk);
        $display("frame %s: valid=%0b data=0x%02h fe=%0b pe=%0b brk=%0b", tag, valid, data,
                 frame_error, parity_error, break_detect);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_data"}, 32'(data), 32'(d));
        check({tag, "_fe"}, 32'(frame_error), 32'(fe));
        check({tag, "_pe"}, 32'(parity_error), 32'(pe));
        check({tag, "_brk"}, 32'(break_detect), 32'(brk));
    endtask

    task automatic accept(input string tag);
        ready = 1'b1;
        @(posedge clock);
        #1;
        ready = 1'b0;
        check({tag, "_accept"}, 32'(valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_fe", 32'(frame_error), 32'd0);
        check("rst_pe", 32'(parity_error), 32'd0);
        check("rst_brk", 32'(break_detect), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        // 0xA5, no parity, one stop; result must appear exactly at edge 155
        drive_start_data(8'hA5);
        rxd = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("a5_early", 32'(valid), 32'd0);
        @(posedge clock);
        #1;
        check_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (5 + BT) @(posedge clock);
        #1;
        accept("a5");

        // Even parity, 0x03: parity bit 1 is wrong, parity bit 0 is right
        parity_mode = 2'b01;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_frame("par_bad", 8'h03, 1'b0, 1'b1, 1'b0);
        accept("par_bad");
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_frame("par_ok", 8'h03, 1'b0, 1'b0, 1'b0);
        accept("par_ok");
        parity_mode = 2'b00;

        // 4-cycle glitch: false start, no result
        r0 = rise_cnt;
        rxd = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        rxd = 1'b1;
        repeat (3 * BT) @(posedge clock);
        #1;
        $display("glitch: valid=%0b rises=%0d", valid, rise_cnt - r0);
        check("glitch_rise", 32'(rise_cnt - r0), 32'd0);
        check("glitch_valid", 32'(valid), 32'd0);

        // 0x5A; configuration changed mid-frame must not take effect
        drive_bit(1'b0);
        parity_mode = 2'b01;
        two_stop = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(r5a(i));
        drive_bit(1'b1);
        repeat (BT) @(posedge clock);
        #1;
        check_frame("f5a", 8'h5A, 1'b0, 1'b0, 1'b0);
        parity_mode = 2'b00;
        two_stop = 1'b0;
        accept("f5a");

        // Back-to-back with ready low: second frame dropped, one overrun
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_frame("ovr", 8'h11, 1'b0, 1'b0, 1'b0);
        check("ovr_count", 32'(ovr_cnt - o0), 32'd1);
        accept("ovr");

        // Same, but ready high in the completion cycle of the second frame
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_start_data(8'h22);
        rxd = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        ready = 1'b1;
        @(posedge clock);
        #1;
        ready = 1'b0;
        check_frame("rdy", 8'h22, 1'b0, 1'b0, 1'b0);
        check("rdy_ovr", 32'(ovr_cnt - o0), 32'd0);
        repeat (5 + BT) @(posedge clock);
        #1;
        accept("rdy");

        // Break: line low for 20 bit times
        r0 = rise_cnt;
        o0 = ovr_cnt;
        rxd = 1'b0;
        repeat (20 * BT) @(posedge clock);
        #1;
        check("brk_rise_low", 32'(rise_cnt - r0), 32'd1);
        check_frame("brk", 8'h00, 1'b1, 1'b0, 1'b1);
        rxd = 1'b1;
        repeat (2 * BT) @(posedge clock);
        #1;
        check("brk_rise_high", 32'(rise_cnt - r0), 32'd1);
        check("brk_ovr", 32'(ovr_cnt - o0), 32'd0);
        accept("brk");

        // Two stop bits, second one low: frame error only
        two_stop = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("stop2", 8'h55, 1'b1, 1'b0, 1'b0);
        accept("stop2");

        // Leave a flagged frame pending, then reset during DATA of 0xC3
        parity_mode = 2'b01;
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_frame("pend", 8'h55, 1'b1, 1'b1, 1'b0);
        parity_mode = 2'b00;
        two_stop = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        #3;
        reset_n = 1'b0;
        #2;
        check("mrst_valid", 32'(valid), 32'd0);
        check("mrst_data", 32'(data), 32'd0);
        check("mrst_fe", 32'(frame_error), 32'd0);
        check("mrst_pe", 32'(parity_error), 32'd0);
        check("mrst_brk", 32'(break_detect), 32'd0);
        check("mrst_ovr", 32'(overrun), 32'd0);
        rxd = 1'b1;
        #2;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("mrst_after", 32'(valid), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_frame("f3c", 8'h3C, 1'b0, 1'b0, 1'b0);
        accept("f3c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic r5a(input int i);
        logic [7:0] v;
        v = 8'h5A;
        return v[i];
    endfunction

endmodule
